// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared types and constants for the BCD stopwatch display scanner
package bcd_display_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam int DIG_TENS_MS = 0;
  localparam int DIG_HUND_MS = 1;
  localparam int DIG_SEC = 2;
  localparam int DIG_TENS_SEC = 3;
  localparam int DIG_MIN = 4;
  localparam int DIG_TENS_MIN = 5;
  localparam logic [5:0] DP_MASK = 6'b010100;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: active-high gfedcba decoder, dash for non-decimal nibbles
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: frame-snapshotted six-digit multiplexed 7-segment driver for MM:SS.hh
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int ON_CYCLES = 3,
  parameter int BLANK_CYCLES = 1,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic        i_rtcclk,
  input  logic        rst,
  input  logic [23:0] i_count,
  input  logic        i_enable,
  input  logic        i_freeze,
  input  logic        i_lzb_en,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [5:0]  o_an,
  output logic        o_frame_start,
  output logic        o_frozen
);
  localparam int M = ON_CYCLES > BLANK_CYCLES ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW = M > 1 ? $clog2(M) : 1;
  localparam logic [CW-1:0] ON_LAST = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam state_t FIRST = BLANK_CYCLES > 0 ? BLANK : ON;
  state_t state, nstate;
  logic [2:0] idx, nidx;
  logic [CW-1:0] cnt, ncnt;
  logic [23:0] snap, nsnap;
  logic nfrozen, nfs, blank;
  logic [5:0] lzb;
  logic [6:0] dec;
  always_comb begin
    nstate = state;
    nidx = idx;
    ncnt = cnt;
    nsnap = snap;
    nfrozen = o_frozen;
    nfs = 1'b0;
    if (!i_enable) begin
      nstate = IDLE;
      nidx = 3'd0;
      ncnt = '0;
    end else if (state == IDLE) begin
      nstate = FIRST;
      nidx = 3'd0;
      ncnt = '0;
      nfs = 1'b1;
    end else if (state == BLANK) begin
      nstate = cnt == BL_LAST ? ON : BLANK;
      ncnt = cnt == BL_LAST ? '0 : cnt + 1'b1;
    end else if (cnt == ON_LAST) begin
      nstate = FIRST;
      ncnt = '0;
      nidx = idx == 3'd5 ? 3'd0 : idx + 3'd1;
      nfs = idx == 3'd5;
    end else begin
      ncnt = cnt + 1'b1;
    end
    if (nfs) begin
      nfrozen = i_freeze;
      nsnap = i_freeze ? snap : i_count;
    end
  end
  // cascade from the most significant digit so only true leading zeros go dark
  assign lzb[5] = i_lzb_en && nsnap[23:20] == 4'd0;
  assign lzb[4] = lzb[5] && nsnap[19:16] == 4'd0;
  assign lzb[3] = lzb[4] && nsnap[15:12] == 4'd0;
  assign lzb[2:0] = 3'b000;
  assign blank = nstate == IDLE || lzb[nidx];
  bcd_to_7seg u_dec (.bcd(nsnap[{nidx, 2'b00} +: 4]), .seg(dec));
  always_ff @(posedge i_rtcclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= 3'd0;
      cnt <= '0;
      snap <= 24'h0;
      o_frozen <= 1'b0;
      o_frame_start <= 1'b0;
      o_an <= {6{ACTIVE_LOW}};
      o_seg <= {7{ACTIVE_LOW}};
      o_dp <= ACTIVE_LOW;
    end else begin
      state <= nstate;
      idx <= nidx;
      cnt <= ncnt;
      snap <= nsnap;
      o_frozen <= nfrozen;
      o_frame_start <= nfs;
      o_an <= (nstate == ON ? 6'b1 << nidx : 6'b0) ^ {6{ACTIVE_LOW}};
      o_seg <= (blank ? SEG_OFF : dec) ^ {7{ACTIVE_LOW}};
      o_dp <= (!blank && DP_MASK[nidx]) ^ ACTIVE_LOW;
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: scoreboard bench comparing every scan cycle against spec-derived frames
module tb_bcd_display_scanner;
  logic clk = 0, rst = 0, en = 0, frz = 0, lzb = 0;
  logic [23:0] cnt_in = 24'h0;
  logic [6:0] seg;
  logic dp, fs, fz;
  logic [5:0] an;
  logic [15:0] q[$];
  logic [15:0] got, exp;
  int tests = 0, fails = 0;

  bcd_display_scanner dut (
    .i_rtcclk(clk), .rst(rst), .i_count(cnt_in), .i_enable(en), .i_freeze(frz),
    .i_lzb_en(lzb), .o_seg(seg), .o_dp(dp), .o_an(an), .o_frame_start(fs), .o_frozen(fz)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] seg_ah(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // expected packing: {frame_start, frozen, dp, an[5:0], seg[6:0]}
  task automatic push_frame(input logic [23:0] v, input logic lz, input logic f);
    for (int d = 0; d < 6; d++) begin
      logic [3:0] n;
      logic b, p;
      logic [6:0] s;
      logic [5:0] a;
      n = v[d*4 +: 4];
      b = lz && ((d == 5 && v[23:20] == 0) || (d == 4 && v[23:16] == 0) || (d == 3 && v[23:12] == 0));
      s = b ? 7'h7F : ~seg_ah(n);
      p = !(!b && (d == 2 || d == 4));
      a = ~(6'b1 << d);
      q.push_back({d == 0, f, p, 6'h3F, s});
      for (int c = 0; c < 3; c++) q.push_back({1'b0, f, p, a, s});
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    tests++;
    if ({fs, fz, dp, an, seg} !== {1'b0, 1'b0, 1'b1, 6'h3F, 7'h7F}) begin
      fails++;
      $display("FAIL reset got %h exp %h", {fs, fz, dp, an, seg}, {1'b0, 1'b0, 1'b1, 6'h3F, 7'h7F});
    end
    rst = 0;
  endtask

  task automatic test_scan;
    cnt_in = 24'h012345; lzb = 1; en = 1;
    push_frame(24'h012345, 1, 0);
    push_frame(24'h012345, 1, 0);
    repeat (48) begin
      @(negedge clk);
      exp = q.pop_front(); got = {fs, fz, dp, an, seg}; tests++;
      if (got !== exp) begin fails++; $display("FAIL scan got %h exp %h", got, exp); end
    end
  endtask

  task automatic test_lzb;
    cnt_in = 24'h000512;
    push_frame(24'h000512, 1, 0);
    repeat (24) begin
      @(negedge clk);
      exp = q.pop_front(); got = {fs, fz, dp, an, seg}; tests++;
      if (got !== exp) begin fails++; $display("FAIL lzb_on got %h exp %h", got, exp); end
    end
    lzb = 0;
    push_frame(24'h000512, 0, 0);
    repeat (24) begin
      @(negedge clk);
      exp = q.pop_front(); got = {fs, fz, dp, an, seg}; tests++;
      if (got !== exp) begin fails++; $display("FAIL lzb_off got %h exp %h", got, exp); end
    end
  endtask

  task automatic test_freeze;
    cnt_in = 24'h123456;
    push_frame(24'h123456, 0, 0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp = q.pop_front(); got = {fs, fz, dp, an, seg}; tests++;
      if (got !== exp) begin fails++; $display("FAIL midframe got %h exp %h", got, exp); end
      if (i == 9) cnt_in = 24'h654321;
    end
    frz = 1; cnt_in = 24'h999999;
    push_frame(24'h123456, 0, 1);
    repeat (24) begin
      @(negedge clk);
      exp = q.pop_front(); got = {fs, fz, dp, an, seg}; tests++;
      if (got !== exp) begin fails++; $display("FAIL frozen got %h exp %h", got, exp); end
    end
    frz = 0;
    push_frame(24'h999999, 0, 0);
    repeat (24) begin
      @(negedge clk);
      exp = q.pop_front(); got = {fs, fz, dp, an, seg}; tests++;
      if (got !== exp) begin fails++; $display("FAIL unfrozen got %h exp %h", got, exp); end
    end
  endtask

  task automatic test_enable_drop;
    cnt_in = 24'h0B0000;
    push_frame(24'h0B0000, 0, 0);
    repeat (14) begin
      @(negedge clk);
      exp = q.pop_front(); got = {fs, fz, dp, an, seg}; tests++;
      if (got !== exp) begin fails++; $display("FAIL pre_drop got %h exp %h", got, exp); end
    end
    en = 0;
    q.delete();
    repeat (2) q.push_back({1'b0, 1'b0, 1'b1, 6'h3F, 7'h7F});
    repeat (2) begin
      @(negedge clk);
      exp = q.pop_front(); got = {fs, fz, dp, an, seg}; tests++;
      if (got !== exp) begin fails++; $display("FAIL idle got %h exp %h", got, exp); end
    end
    en = 1;
    push_frame(24'h0B0000, 0, 0);
    repeat (24) begin
      @(negedge clk);
      exp = q.pop_front(); got = {fs, fz, dp, an, seg}; tests++;
      if (got !== exp) begin fails++; $display("FAIL reenable got %h exp %h", got, exp); end
    end
  endtask

  task automatic test_async_reset;
    repeat (2) @(negedge clk);
    tests++;
    if (an !== 6'h3E) begin fails++; $display("FAIL pre_reset_an got %h exp %h", an, 6'h3E); end
    #1 rst = 1;
    #1;
    tests++;
    if ({fs, fz, dp, an, seg} !== {1'b0, 1'b0, 1'b1, 6'h3F, 7'h7F}) begin
      fails++;
      $display("FAIL async_reset got %h exp %h", {fs, fz, dp, an, seg}, {1'b0, 1'b0, 1'b1, 6'h3F, 7'h7F});
    end
    @(negedge clk);
    rst = 0;
    en = 0;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_lzb;
    test_freeze;
    test_enable_drop;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
